seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Display back-end directly downstream of the data memory's memory-mapped `digi` register (address 0x40000010).
- Captures each software write of `digi` into a 4-digit frame buffer, then autonomously time-multiplexes the four digits onto the board's 7-segment anodes and cathodes.
- A blanking gap between digits suppresses ghosting.
- Software writes each digit once instead of bit-banging the scan.

Parameters:
- ON_CYC, 100000, cycles each digit is lit (1 ms at 100 MHz); must be ≥1.
- BLANK_CYC, 1000, cycles of all-off between digits; must be ≥1.
- CNT_W, 17, width of the dwell counter; must hold max(ON_CYC, BLANK_CYC)-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- digi  in  12  `digi` register value; [11:8] = digit select, one-hot active-high; [7:0] = segment pattern {dp,g,f,e,d,c,b,a}, 1 = lit
- an  out  4  anode drives, active-low, an[k] = digit k
- seg  out  8  cathode drives {dp,g..a}, active-low
- frame_tick  out  1  one-cycle pulse at the end of each full 4-digit frame

Behaviour:
- Reset (reset=0), asynchronous, takes effect immediately:
  - an=4'hF, seg=8'hFF, frame_tick=0
  - fb[0..3]=8'h00, digi_q=12'h001, state=BLANK, idx=0, cnt=0
- Capture:
  - digi_q registers digi every cycle.
  - On any cycle where digi != digi_q, for each k with digi[8+k]=1, fb[k] <= digi[7:0] at the next edge.
  - Multiple select bits set: all selected slots are written.
  - digi[11:8]=0: no write.
  - An unchanged digi held for many cycles does not re-write.
- Scan FSM, two states:
  - BLANK: an=4'hF, seg=8'hFF. cnt counts 0..BLANK_CYC-1. On cnt==BLANK_CYC-1: state<=ON, cnt<=0.
  - ON: an = ~(4'b0001<<idx); seg = ~fb[idx], read live, so a buffer write to the lit digit appears on the cycle after the fb update. cnt counts 0..ON_CYC-1. On cnt==ON_CYC-1: state<=BLANK, cnt<=0, idx<=idx+1 (2-bit wrap 3→0).
  - frame_tick=1 for exactly the cycle where state==ON, idx==3, cnt==ON_CYC-1. Otherwise 0.
- Outputs depend only on registered state (state, idx, fb). There is no combinational path from digi to an/seg.
- After reset release: BLANK_CYC blank cycles, then digit 0.
- Frame period = 4*(ON_CYC+BLANK_CYC) cycles.
- Simultaneous capture and scan to the same slot: scan shows the old value this cycle and the new value next cycle.
- Reset mid-frame: everything returns to the reset state. The buffer is lost; software must rewrite it.

Optional Feature:
- Macro: SEGSCAN_BCD_DECODE_EN.
- Defined: the captured byte is interpreted as {dp, 3'bx, hex[3:0]}. fb stores the decoded pattern: standard hex table (0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07, 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71), with bit7 = dp.
- Undefined: the raw pattern is stored unchanged.
- Decode occurs at capture, so scan timing is identical in both builds.

Test Plan (ON_CYC=4, BLANK_CYC=2, macro undefined unless stated):
- Reset and idle:
  - Stimulus: hold reset=0, then release.
  - Required: an=F, seg=FF, frame_tick=0 during reset; 2 blank cycles, then an=1110/seg=FF for 4 cycles; then 2 blank cycles, then an=1101.
- Single digit:
  - Stimulus: digi=12'h13F.
  - Required: while digit 0 is lit, an=1110, seg=C0. Digits 1–3 show seg=FF.
- Full frame:
  - Stimulus: write 12'h13F, 12'h206, 12'h45B, 12'h84F, then hold.
  - Required: lit sequence an=1110/C0, 1101/F9, 1011/A4, 0111/B0, each 4 cycles separated by 2 blank cycles. frame_tick pulses once every 24 cycles, on the last lit cycle of digit 3.
- No-select / multi-select:
  - Stimulus: digi=12'h0FF.
  - Required: no slot changes.
  - Stimulus: digi=12'h306.
  - Required: digits 0 and 1 both show seg=F9.
- Reset mid-ON:
  - Stimulus: reset=0 during digit 2 lit.
  - Required: an=F, seg=FF within the same cycle with no clock edge. After release, all digits show FF until rewritten.
- Macro build (SEGSCAN_BCD_DECODE_EN):
  - Stimulus: digi=12'h885.
  - Required: digit 3 shows an=0111, seg=12 (hex 5 with dp lit).

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit 7-segment scan driver fed by the memory-mapped `digi` register.
// Optional build macro SEGSCAN_BCD_DECODE_EN: store hex-decoded patterns instead of raw segments.
module seg_scan_driver #(
  parameter int unsigned ON_CYC    = 100000,
  parameter int unsigned BLANK_CYC = 1000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] digi,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int unsigned DIGITS = 4;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      digi_q;
  logic [7:0]       fb_q [DIGITS];
  logic [7:0]       cap_byte;
  logic             cap_en;

`ifdef SEGSCAN_BCD_DECODE_EN
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Bits [6:4] of the byte carry no meaning in the decoded format.
  logic unused_bits;
  assign unused_bits = ^digi[6:4];
  assign cap_byte    = {digi[7], hex_to_seg(digi[3:0])};
`else
  assign cap_byte = digi[7:0];
`endif

  // A write is a change of the register value; holding it does nothing.
  assign cap_en = (digi != digi_q);

  // Frame buffer capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digi_q <= 12'h001;
      for (int k = 0; k < DIGITS; k++) fb_q[k] <= 8'h00;
    end else begin
      digi_q <= digi;
      for (int k = 0; k < DIGITS; k++) begin
        if (cap_en && digi[8+k]) fb_q[k] <= cap_byte;
      end
    end
  end

  // Scan state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and drive decode from registered state only.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    an         = 4'hF;
    seg        = 8'hFF;
    frame_tick = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end
      end
      ST_ON: begin
        an  = ~(4'(4'b0001 << idx_q));
        seg = ~fb_q[idx_q];
        if (cnt_q == ON_LAST) begin
          state_d    = ST_BLANK;
          cnt_d      = '0;
          idx_d      = idx_q + 2'd1;
          frame_tick = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: per-cycle expected drives queued from a frame-position model.
// Build with +define+SEGSCAN_BCD_DECODE_EN to check the decoded-capture variant.
module tb_seg_scan_driver;

  localparam int unsigned ON_CYC    = 4;
  localparam int unsigned BLANK_CYC = 2;
  localparam int unsigned SLOT      = ON_CYC + BLANK_CYC;
  localparam int unsigned FRAME     = 4 * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] digi;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  int          t;
  logic [7:0]  fb_m [4];
  logic [11:0] last_digi;
  logic        pend;
  logic [11:0] pend_digi;
  logic [12:0] exp_q [$];

  seg_scan_driver #(.ON_CYC(ON_CYC), .BLANK_CYC(BLANK_CYC), .CNT_W(17)) dut (
    .clk(clk), .reset(reset), .digi(digi),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

`ifdef SEGSCAN_BCD_DECODE_EN
  function automatic logic [7:0] stored(input logic [7:0] b);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return {b[7], tab[b[3:0]]};
  endfunction
`else
  function automatic logic [7:0] stored(input logic [7:0] b);
    return b;
  endfunction
`endif

  function automatic logic [12:0] expected_at(input int tt);
    int pos, d;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    pos = tt % FRAME;
    d   = pos / SLOT;
    if ((pos % SLOT) < BLANK_CYC) begin
      e_an  = 4'hF;
      e_seg = 8'hFF;
    end else begin
      e_an  = 4'hF;
      e_an[d] = 1'b0;
      e_seg = ~fb_m[d];
    end
    return {e_an, e_seg, (pos == FRAME - 1)};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s t=%0d: observed an/seg/tick=%h expected %h", tag, t, obs, exp_v);
    end
  endtask

  // Drive a new register value just after the sampling edge; it lands at the next posedge.
  task automatic drive(input logic [11:0] d);
    digi = d;
    pend = (d != last_digi) && (d[11:8] != 4'h0);
    pend_digi = d;
    last_digi = d;
  endtask

  task automatic cycle(input string tag);
    logic [12:0] e;
    @(posedge clk);
    t++;
    if (pend) begin
      for (int k = 0; k < 4; k++)
        if (pend_digi[8+k]) fb_m[k] = stored(pend_digi[7:0]);
      pend = 1'b0;
    end
    exp_q.push_back(expected_at(t));
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, {an, seg, frame_tick}, e);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic release_reset();
    for (int k = 0; k < 4; k++) fb_m[k] = 8'h00;
    last_digi = 12'h001;
    pend = (digi != last_digi) && (digi[11:8] != 4'h0);
    pend_digi = digi;
    last_digi = digi;
    reset = 1'b1;
    t = 0;
  endtask

  initial begin
    reset = 1'b0;
    digi  = 12'h000;
    pend  = 1'b0;
    pend_digi = 12'h000;
    last_digi = 12'h001;
    t = 0;
    for (int k = 0; k < 4; k++) fb_m[k] = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", {an, seg, frame_tick}, {4'hF, 8'hFF, 1'b0});
    end
    release_reset();
    run("reset_idle", FRAME);

    drive(12'h13F);
    run("single_digit", FRAME);

    drive(12'h206); cycle("full_frame_wr");
    drive(12'h45B); cycle("full_frame_wr");
    drive(12'h84F); cycle("full_frame_wr");
    run("full_frame", 2 * FRAME);

    drive(12'h0FF);
    run("no_select", FRAME);
    drive(12'h306);
    run("multi_select", FRAME);

    for (int i = 0; i < FRAME && (t % FRAME) != 2 * SLOT + BLANK_CYC + 1; i++)
      cycle("seek_digit2");
    checks++;
    assert (an === 4'b1011) else begin
      errors++;
      $error("FAIL seek_digit2: observed an=%b expected 1011", an);
    end
    #2 reset = 1'b0;
    #1 check("reset_async", {an, seg, frame_tick}, {4'hF, 8'hFF, 1'b0});
    digi = 12'h000;
    @(negedge clk);
    check("reset_mid_hold", {an, seg, frame_tick}, {4'hF, 8'hFF, 1'b0});
    release_reset();
    run("after_reset", FRAME);

    drive(12'h885);
    run("digit3_dp", FRAME);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
